// File: rtl/mdu_e.sv
// E-stage multiply/divide unit: multi-cycle MULT/MULTU/DIV/DIVU into HI/LO, single-cycle MTHI/MTLO.
// Operands are latched at acceptance; the result is computed from the latched copy at the final cycle.
module mdu_e #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] rs_in,
  input  logic [31:0] rt_in,
  input  logic [2:0]  mdu_op,
  input  logic        start,
  input  logic        cancel,
  input  logic        rd_sel,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [31:0] mdu_rdata
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] MultCnt = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivCnt  = CntW'(DIV_CYCLES);
  localparam logic [CntW-1:0] LastCnt = CntW'(1);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic [2:0]      op_q, op_d;

  logic        is_mul, mul_sgn, div_sgn;
  logic [63:0] mul_a, mul_b, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;
  logic        in_muldiv;

  assign is_mul  = (op_q == OpMult) || (op_q == OpMultu);
  assign mul_sgn = (op_q == OpMult);
  assign div_sgn = (op_q == OpDiv);

  // Sign-extending to 64 bits lets one unsigned multiplier serve both MULT and MULTU.
  assign mul_a = {{32{mul_sgn & a_q[31]}}, a_q};
  assign mul_b = {{32{mul_sgn & b_q[31]}}, b_q};
  assign prod  = mul_a * mul_b;

  // Magnitude division; 0x80000000 / -1 falls out as 0x80000000 rem 0 without special-casing.
  assign a_neg = div_sgn & a_q[31];
  assign b_neg = div_sgn & b_q[31];
  assign a_mag = a_neg ? (~a_q + 32'd1) : a_q;
  assign b_mag = b_neg ? (~b_q + 32'd1) : b_q;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign quo   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem   = a_neg ? (~r_mag + 32'd1) : r_mag;

  assign in_muldiv = (mdu_op == OpMult) || (mdu_op == OpMultu) ||
                     (mdu_op == OpDiv)  || (mdu_op == OpDivu);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    unique case (state_q)
      StIdle: begin
        if (start && !cancel) begin
          unique case (mdu_op)
            OpMult, OpMultu, OpDiv, OpDivu: begin
              a_d     = rs_in;
              b_d     = rt_in;
              op_d    = mdu_op;
              cnt_d   = ((mdu_op == OpMult) || (mdu_op == OpMultu)) ? MultCnt : DivCnt;
              state_d = StRun;
            end
            OpMthi:  hi_d = rs_in;
            OpMtlo:  lo_d = rs_in;
            default: ;
          endcase
        end
      end
      StRun: begin
        if (cnt_q == LastCnt) begin
          state_d = StIdle;
          cnt_d   = '0;
          if (is_mul) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end else if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quo;
          end
        end else begin
          cnt_d = cnt_q - LastCnt;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
    end
  end

  assign busy      = (state_q == StRun);
  assign stall_req = busy | (start & in_muldiv & ~cancel);
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
  assign mdu_rdata = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_e.sv
// Randomized scoreboard bench for mdu_e: a driver issues ops and queues expected HI/LO and latency,
// a monitor checks each completion when busy falls.
module tb_mdu_e;

  localparam int MultN = 5;
  localparam int DivN  = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] rs_in, rt_in;
  logic [2:0]  mdu_op;
  logic        start, cancel, rd_sel;
  logic        busy, stall_req;
  logic [31:0] hi_out, lo_out, mdu_rdata;

  mdu_e #(.MULT_CYCLES(MultN), .DIV_CYCLES(DivN)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rs_in     (rs_in),
    .rt_in     (rt_in),
    .mdu_op    (mdu_op),
    .start     (start),
    .cancel    (cancel),
    .rd_sel    (rd_sel),
    .busy      (busy),
    .stall_req (stall_req),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .mdu_rdata (mdu_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model straight from the arithmetic rules.
  task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      ps;
    logic [63:0] pu;
    int          sa, sb;
    case (op)
      3'd1: begin
        ps = longint'($signed(a)) * longint'($signed(b));
        {m_hi, m_lo} = ps;
      end
      3'd2: begin
        pu = {32'd0, a} * {32'd0, b};
        {m_hi, m_lo} = pu;
      end
      3'd3: begin
        if (b != 32'd0) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            m_lo = 32'h8000_0000;
            m_hi = 32'd0;
          end else begin
            sa = a;
            sb = b;
            m_lo = sa / sb;
            m_hi = sa % sb;
          end
        end
      end
      3'd4: begin
        if (b != 32'd0) begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endtask

  // Monitor: every busy falling edge is one completion.
  bit prev_busy = 1'b0;
  int bcnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_busy = 1'b0;
      bcnt = 0;
    end else begin
      if (busy) bcnt++;
      if (prev_busy && !busy) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_completion", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("done_hi", {32'd0, hi_out}, {32'd0, e.hi});
          chk("done_lo", {32'd0, lo_out}, {32'd0, e.lo});
          chk("busy_cycles", 64'(bcnt), 64'(e.cycles));
        end
        bcnt = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic check_regs(input string tag);
    chk({tag, "_hi"}, {32'd0, hi_out}, {32'd0, m_hi});
    chk({tag, "_lo"}, {32'd0, lo_out}, {32'd0, m_lo});
    rd_sel = 1'b1;
    #1 chk({tag, "_rdata_hi"}, {32'd0, mdu_rdata}, {32'd0, m_hi});
    rd_sel = 1'b0;
    #1 chk({tag, "_rdata_lo"}, {32'd0, mdu_rdata}, {32'd0, m_lo});
  endtask

  // Assumes the unit is idle when called.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit cn);
    bit md;
    md = (op >= 3'd1) && (op <= 3'd4);
    @(negedge clk);
    mdu_op = op;
    rs_in  = a;
    rt_in  = b;
    cancel = cn;
    start  = 1'b1;
    #1 chk("stall_req_issue", {63'd0, stall_req}, {63'd0, md && !cn});
    @(posedge clk);
    #1;
    start  = 1'b0;
    cancel = 1'b0;
    mdu_op = 3'($urandom);
    rs_in  = $urandom;
    rt_in  = $urandom;
    if (!cn) begin
      ref_op(op, a, b);
      if (md) sb_q.push_back('{hi: m_hi, lo: m_lo, cycles: (op <= 3'd2) ? MultN : DivN});
    end
    chk("busy_after_issue", {63'd0, busy}, {63'd0, md && !cn});
  endtask

  // Waits for idle; with noise, keeps presenting new starts and fresh operands while busy.
  task automatic wait_idle(input bit noise);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      chk("stall_while_busy", {63'd0, stall_req}, 64'd1);
      n++;
      if (n > 60) begin
        chk("idle_timeout", 64'd1, 64'd0);
        break;
      end
      if (noise) begin
        start  = 1'b1;
        mdu_op = 3'($urandom_range(1, 6));
        rs_in  = $urandom;
        rt_in  = $urandom;
        cancel = 1'($urandom);
      end
    end
    start  = 1'b0;
    cancel = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          sel;
    reset_n = 1'b0;
    rs_in   = 32'hDEAD_BEEF;
    rt_in   = 32'h1234_5678;
    mdu_op  = 3'd1;
    start   = 1'b1;
    cancel  = 1'b0;
    rd_sel  = 1'b0;

    // Reset holds everything at zero even with start asserted.
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    check_regs("rst");
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", {63'd0, busy}, 64'd0);
    chk("post_rst_stall", {63'd0, stall_req}, 64'd0);
    check_regs("post_rst");

    // Directed arithmetic.
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_idle(1'b0);
    check_regs("mult_neg");
    issue(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_idle(1'b0);
    check_regs("multu");
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle(1'b0);
    check_regs("div_neg");
    issue(3'd4, 32'd7, 32'd0, 1'b0);
    wait_idle(1'b0);
    check_regs("divu_zero");
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle(1'b0);
    check_regs("div_ovf");

    // Starts during busy are ignored; operands change freely after acceptance.
    issue(3'd1, 32'h0001_0003, 32'hFFFF_0007, 1'b0);
    wait_idle(1'b1);
    check_regs("overlap");

    // cancel blocks acceptance.
    issue(3'd1, 32'd9, 32'd9, 1'b1);
    wait_idle(1'b0);
    check_regs("cancel_mult");
    issue(3'd5, 32'h0000_1234, 32'd0, 1'b1);
    check_regs("cancel_mthi");
    issue(3'd5, 32'h0000_1234, 32'd0, 1'b0);
    check_regs("mthi");
    issue(3'd6, 32'hCAFE_0001, 32'd0, 1'b0);
    check_regs("mtlo");

    // Reset in the middle of a divide.
    issue(3'd4, 32'd1000, 32'd7, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    sb_q.delete();
    m_hi = 32'd0;
    m_lo = 32'd0;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    check_regs("midrst");
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (DivN + 3) @(negedge clk);
    chk("midrst_after_busy", {63'd0, busy}, 64'd0);
    check_regs("midrst_after");

    // Random ops, including reserved/none, cancels and corner operands.
    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end else if (sel == 2) begin
        a = 32'($signed(-$urandom_range(1, 100)));
        b = 32'($urandom_range(1, 9));
      end
      issue(op, a, b, $urandom_range(0, 4) == 0);
      wait_idle(1'($urandom));
      check_regs("rand");
    end

    repeat (2) @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
